// File: rtl/logic_reduce_pipe.sv
// Pipelined bitwise reduction of NUM_IN operands (AND/OR/XOR/NAND) through a
// registered binary tree, with a single global stall enable for backpressure.
module logic_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
);

  localparam int LAT = $clog2(NUM_IN);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // NAND reduces as AND inside the tree; the inversion happens once at the output.
  function automatic logic [WIDTH-1:0] combine(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_OR:   combine = a | b;
      OP_XOR:  combine = a ^ b;
      default: combine = a & b;
    endcase
  endfunction

  logic adv;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  for (genvar s = 0; s < LAT; s++) begin : stg
    localparam int PCNT = (NUM_IN + (1 << s) - 1) >> s;
    localparam int CNT  = (PCNT + 1) / 2;

    logic                   vld_p;
    logic [1:0]             op_p;
    logic [CNT*WIDTH-1:0]   dat_p;

    logic                   src_vld;
    logic [1:0]             src_op;
    logic [PCNT*WIDTH-1:0]  src_dat;
    logic [CNT*WIDTH-1:0]   red;

    if (s == 0) begin : g_src
      assign src_vld = in_valid && adv;
      assign src_op  = in_op;
      assign src_dat = in_data;
    end else begin : g_src
      assign src_vld = stg[s-1].vld_p;
      assign src_op  = stg[s-1].op_p;
      assign src_dat = stg[s-1].dat_p;
    end

    for (genvar k = 0; k < CNT; k++) begin : g_lane
      if (2*k + 1 < PCNT) begin : g_pair
        assign red[k*WIDTH +: WIDTH] = combine(src_op,
                                               src_dat[2*k*WIDTH +: WIDTH],
                                               src_dat[(2*k+1)*WIDTH +: WIDTH]);
      end else begin : g_pass
        assign red[k*WIDTH +: WIDTH] = src_dat[2*k*WIDTH +: WIDTH];
      end
    end

    // ---- stage s register: bubbles load zeros so undefined inputs never propagate
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= 1'b0;
        op_p  <= OP_AND;
        dat_p <= '0;
      end else if (adv) begin
        vld_p <= src_vld;
        op_p  <= src_vld ? src_op : OP_AND;
        dat_p <= src_vld ? red : '0;
      end
    end
  end

  // ---- output: final stage holds a single WIDTH-bit lane
  assign out_valid = stg[LAT-1].vld_p;
  assign out_data  = (stg[LAT-1].op_p == OP_NAND) ? ~stg[LAT-1].dat_p : stg[LAT-1].dat_p;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Bench for logic_reduce_pipe: three configurations (8x4, 1x2, 4x5), a fold-based
// reference model with an in-order scoreboard, and hand-computed directed vectors.
module tb_logic_reduce_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Config A: WIDTH=8, NUM_IN=4, LAT=2
  logic        a_vld = 1'b0, a_ord = 1'b1, a_rdy, a_ov;
  logic [1:0]  a_op  = 2'b00;
  logic [31:0] a_dat = 32'h0;
  logic [7:0]  a_od;

  // Config B: WIDTH=1, NUM_IN=2, LAT=1
  logic        b_vld = 1'b0, b_ord = 1'b1, b_rdy, b_ov;
  logic [1:0]  b_op  = 2'b00;
  logic [1:0]  b_dat = 2'b00;
  logic        b_od;

  // Config C: WIDTH=4, NUM_IN=5, LAT=3 (odd leftover operand)
  logic        c_vld = 1'b0, c_ord = 1'b1, c_rdy, c_ov;
  logic [1:0]  c_op  = 2'b00;
  logic [19:0] c_dat = 20'h0;
  logic [3:0]  c_od;

  logic_reduce_pipe #(.WIDTH(8), .NUM_IN(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_vld), .in_ready(a_rdy), .in_op(a_op),
    .in_data(a_dat), .out_valid(a_ov), .out_ready(a_ord), .out_data(a_od));

  logic_reduce_pipe #(.WIDTH(1), .NUM_IN(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_vld), .in_ready(b_rdy), .in_op(b_op),
    .in_data(b_dat), .out_valid(b_ov), .out_ready(b_ord), .out_data(b_od));

  logic_reduce_pipe #(.WIDTH(4), .NUM_IN(5)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_vld), .in_ready(c_rdy), .in_op(c_op),
    .in_data(c_dat), .out_valid(c_ov), .out_ready(c_ord), .out_data(c_od));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: left fold from the op's identity element, then optional inversion.
  function automatic logic [7:0] ref_reduce(input logic [1:0] op, input logic [63:0] d,
                                            input int n, input int w);
    logic [7:0] m, acc, x;
    m   = 8'((1 << w) - 1);
    acc = (op == 2'b01 || op == 2'b10) ? 8'h00 : m;
    for (int k = 0; k < n; k++) begin
      x = 8'(d >> (k * w)) & m;
      case (op)
        2'b01:   acc = acc | x;
        2'b10:   acc = acc ^ x;
        default: acc = acc & x;
      endcase
    end
    if (op == 2'b11) acc = ~acc & m;
    return acc;
  endfunction

  // Scoreboards and stall trackers, sampled on the falling edge.
  logic [7:0] qa[$];
  logic [7:0] qc[$];
  bit         sa = 1'b0, sc = 1'b0;
  logic [7:0] pa = 8'h0;
  logic [3:0] pc = 4'h0;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qc.delete();
      sa = 1'b0;
      sc = 1'b0;
    end else begin
      chk("a_in_ready", 64'(a_rdy), 64'(!(a_ov && !a_ord)));
      if (sa) begin
        chk("a_stall_valid", 64'(a_ov), 64'd1);
        chk("a_stall_data", 64'(a_od), 64'(pa));
      end
      if (a_ov && a_ord) begin
        if (qa.size() == 0) chk("a_unexpected_valid", 64'(a_ov), 64'd0);
        else chk("a_result", 64'(a_od), 64'(qa.pop_front()));
      end
      if (a_vld && a_rdy) qa.push_back(ref_reduce(a_op, 64'(a_dat), 4, 8));
      sa = a_ov && !a_ord;
      pa = a_od;

      chk("c_in_ready", 64'(c_rdy), 64'(!(c_ov && !c_ord)));
      if (sc) begin
        chk("c_stall_valid", 64'(c_ov), 64'd1);
        chk("c_stall_data", 64'(c_od), 64'(pc));
      end
      if (c_ov && c_ord) begin
        if (qc.size() == 0) chk("c_unexpected_valid", 64'(c_ov), 64'd0);
        else chk("c_result", 64'(c_od), 64'(qc.pop_front()));
      end
      if (c_vld && c_rdy) qc.push_back(ref_reduce(c_op, 64'(c_dat), 5, 4));
      sc = c_ov && !c_ord;
      pc = c_od;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  exp2 [4] = '{8'h30, 8'hFF, 8'hCC, 8'hCF};
  bit          pv   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  bop5 [4] = '{2'b10, 2'b00, 2'b00, 2'b00};
  logic [31:0] bdt5 [4] = '{32'h01020408, 32'hDEADBEEF, 32'hF3F5F7FF, 32'h0BADF00D};
  logic [7:0]  bex5 [4] = '{8'h0F, 8'h00, 8'hF1, 8'h00};
  logic [1:0]  b_ops [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01};
  logic [1:0]  b_ins [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
  logic        b_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int sent;
    int c;
    bit acc;

    // Pin the reference model to hand-computed values.
    chk("model_and",  64'(ref_reduce(2'b00, 64'hFFF03CFF, 4, 8)), 64'h30);
    chk("model_xor",  64'(ref_reduce(2'b10, 64'hFFF03CFF, 4, 8)), 64'hCC);
    chk("model_nand", 64'(ref_reduce(2'b11, 64'hFFF03CFF, 4, 8)), 64'hCF);
    chk("model_odd",  64'(ref_reduce(2'b00, 64'h3FFFF, 5, 4)), 64'h3);

    // Reset state
    repeat (3) step();
    chk("rst_a_valid", 64'(a_ov), 64'd0);
    chk("rst_a_data",  64'(a_od), 64'd0);
    chk("rst_b_valid", 64'(b_ov), 64'd0);
    chk("rst_c_valid", 64'(c_ov), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_a_in_ready", 64'(a_rdy), 64'd1);
    chk("rst_b_in_ready", 64'(b_rdy), 64'd1);
    chk("rst_c_in_ready", 64'(c_rdy), 64'd1);
    step();

    // Four ops back to back on the same operands
    a_ord = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        a_vld = 1'b1; a_op = 2'(j); a_dat = 32'hFFF03CFF;
      end else a_vld = 1'b0;
      step();
      if (j == 0) chk("t2_lat_valid", 64'(a_ov), 64'd0);
      else if (j <= 4) begin
        chk("t2_valid", 64'(a_ov), 64'd1);
        chk("t2_data", 64'(a_od), 64'(exp2[j-1]));
      end else chk("t2_tail_valid", 64'(a_ov), 64'd0);
    end
    repeat (3) step();

    // Bubbles
    for (int j = 0; j < 5; j++) begin
      if (j < 4) begin
        a_vld = pv[j]; a_op = bop5[j]; a_dat = bdt5[j];
      end else a_vld = 1'b0;
      step();
      if (j >= 1) begin
        chk("t5_valid", 64'(a_ov), 64'(pv[j-1]));
        if (pv[j-1]) chk("t5_data", 64'(a_od), 64'(bex5[j-1]));
      end
    end
    a_vld = 1'b0;
    repeat (3) step();

    // Backpressure: out_ready low for the first 5 cycles
    sent = 0;
    c = 0;
    while (sent < 6 && c < 50) begin
      a_ord = (c >= 5);
      a_vld = 1'b1;
      a_op  = 2'(sent % 4);
      a_dat = 32'h13579BDF ^ (32'h01010101 * 32'(sent));
      #1;
      acc = a_rdy;
      if (c == 2) chk("t4_in_ready_low", 64'(a_rdy), 64'd0);
      step();
      c++;
      if (acc) sent++;
    end
    chk("t4_all_sent", 64'(sent), 64'd6);
    a_vld = 1'b0;
    a_ord = 1'b1;
    repeat (4) step();
    chk("t4_drained", 64'(qa.size()), 64'd0);

    // Reset with two transactions in flight
    a_vld = 1'b1; a_op = 2'b10; a_dat = 32'h12345678;
    step();
    a_dat = 32'h9ABCDEF0;
    step();
    chk("t6_inflight", 64'(a_ov), 64'd1);
    a_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(a_ov), 64'd0);
    chk("t6_rst_data",  64'(a_od), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_in_ready", 64'(a_rdy), 64'd1);
    step();
    a_vld = 1'b1; a_op = 2'b01; a_dat = 32'h00000081;
    step();
    a_vld = 1'b0;
    step();
    chk("t6_valid", 64'(a_ov), 64'd1);
    chk("t6_data",  64'(a_od), 64'h81);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t6_only_one", 64'(a_ov), 64'd0);
    end

    // WIDTH=1, NUM_IN=2: one-cycle latency
    b_ord = 1'b1;
    for (int j = 0; j < 8; j++) begin
      b_vld = 1'b1; b_op = b_ops[j]; b_dat = b_ins[j];
      step();
      chk("t3_valid", 64'(b_ov), 64'd1);
      chk("t3_data",  64'(b_od), 64'(b_exp[j]));
    end
    b_vld = 1'b0;
    step();
    chk("t3_idle", 64'(b_ov), 64'd0);

    // Odd operand count: leftover lane passes through the tree
    c_ord = 1'b1;
    c_vld = 1'b1; c_op = 2'b00; c_dat = 20'h3FFFF;
    step();
    c_op = 2'b10; c_dat = 20'h12345;
    step();
    c_vld = 1'b0;
    step();
    chk("c_odd_valid", 64'(c_ov), 64'd1);
    chk("c_odd_and",   64'(c_od), 64'h3);
    step();
    chk("c_odd_xor",   64'(c_od), 64'h1);
    repeat (3) step();

    // Mixed traffic with random valid/ready
    for (int j = 0; j < 300; j++) begin
      c_vld = 1'($urandom_range(0, 1));
      c_ord = ($urandom_range(0, 3) != 0);
      c_op  = 2'($urandom_range(0, 3));
      c_dat = 20'($urandom);
      step();
    end
    c_vld = 1'b0;
    c_ord = 1'b1;
    repeat (6) step();
    chk("c_drained", 64'(qc.size()), 64'd0);
    chk("a_drained", 64'(qa.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
